// File: rtl/blram_arbiter.sv
// blram_arbiter: two-requester arbiter in front of a 16-bit single-port block RAM
// with a 1-cycle synchronous read.
// Requester 0 (CPU core) and requester 1 (loader/debug DMA) share the port.
// A lock gives one port exclusive use for read-modify-write sequences. A
// starvation counter lets the blocked port through once it has waited
// LOCK_MAX cycles.
// Build option: define BLRAM_ARB_RR_EN for round-robin arbitration when no
// lock is held. Without it, port 0 has fixed priority.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | no lock held, normal arbitration
// ST_LOCK0 | port 0 owns the lock, port 1 may starve
// ST_LOCK1 | port 1 owns the lock, port 0 may starve

module blram_arbiter #(
    parameter int SIZE     = 13,
    parameter int LOCK_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req0,
    input  logic            i_we0,
    input  logic [SIZE-1:0] i_addr0,
    input  logic [15:0]     i_wdata0,
    input  logic            i_lock0,
    output logic            o_gnt0,
    output logic            o_rvalid0,
    output logic [15:0]     o_rdata0,
    input  logic            i_req1,
    input  logic            i_we1,
    input  logic [SIZE-1:0] i_addr1,
    input  logic [15:0]     i_wdata1,
    input  logic            i_lock1,
    output logic            o_gnt1,
    output logic            o_rvalid1,
    output logic [15:0]     o_rdata1,
    output logic            o_ram_we,
    output logic [SIZE-1:0] o_ram_addr,
    output logic [15:0]     o_ram_data_in,
    input  logic [15:0]     i_ram_data_out
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] C_LOCK_MAX = CW'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_rvalid0;
    logic            r_rvalid1;
`ifdef BLRAM_ARB_RR_EN
    logic            r_last_gnt;
`endif

    logic w_locked;
    logic w_owner;
    logic w_req_own;
    logic w_req_oth;
    logic w_lock_own;
    logic w_gnt_own;
    logic w_gnt_oth;
    logic w_relief;
    logic w_release;
    logic w_acquire;
    logic w_gnt0;
    logic w_gnt1;

    assign w_locked   = (r_state != ST_IDLE);
    assign w_owner    = (r_state == ST_LOCK1);
    assign w_req_own  = w_owner ? i_req1 : i_req0;
    assign w_req_oth  = w_owner ? i_req0 : i_req1;
    assign w_lock_own = w_owner ? i_lock1 : i_lock0;
    assign w_gnt_own  = w_owner ? w_gnt1 : w_gnt0;
    assign w_gnt_oth  = w_owner ? w_gnt0 : w_gnt1;
    assign w_relief   = w_locked & w_req_oth & (r_starve_cnt == C_LOCK_MAX);

    // Grant selection: lock owner first unless the other port has waited long enough.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (w_locked) begin
                if (w_relief) begin
                    if (w_owner) w_gnt0 = 1'b1;
                    else         w_gnt1 = 1'b1;
                end else if (w_req_own) begin
                    if (w_owner) w_gnt1 = 1'b1;
                    else         w_gnt0 = 1'b1;
                end
            end else begin
`ifdef BLRAM_ARB_RR_EN
                if (i_req0 && i_req1) begin
                    if (r_last_gnt) w_gnt0 = 1'b1;
                    else            w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = i_req0;
                    w_gnt1 = i_req1;
                end
`else
                w_gnt0 = i_req0;
                w_gnt1 = i_req1 & ~i_req0;
`endif
            end
        end
    end

    // The lock is dropped when the owner stops requesting or takes a grant without lock.
    assign w_release = w_locked & (~w_req_own | (w_gnt_own & ~w_lock_own));
    assign w_acquire = ~w_locked & ((w_gnt0 & i_lock0) | (w_gnt1 & i_lock1));

    assign o_gnt0        = w_gnt0;
    assign o_gnt1        = w_gnt1;
    assign o_ram_we      = (w_gnt0 & i_we0) | (w_gnt1 & i_we1);
    assign o_ram_addr    = w_gnt0 ? i_addr0  : (w_gnt1 ? i_addr1  : '0);
    assign o_ram_data_in = w_gnt0 ? i_wdata0 : (w_gnt1 ? i_wdata1 : '0);
    assign o_rvalid0     = r_rvalid0;
    assign o_rvalid1     = r_rvalid1;
    assign o_rdata0      = r_rvalid0 ? i_ram_data_out : '0;
    assign o_rdata1      = r_rvalid1 ? i_ram_data_out : '0;

    // Lock ownership state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acquire) r_state <= w_gnt1 ? ST_LOCK1 : ST_LOCK0;
                end
                ST_LOCK0, ST_LOCK1: begin
                    if (w_release) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Counts cycles the non-owner is held off; cleared when it is served or stops waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!w_locked || w_release || !w_req_oth || w_gnt_oth) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Read-valid pipeline aligned with the RAM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~i_we0;
            r_rvalid1 <= w_gnt1 & ~i_we1;
        end
    end

`ifdef BLRAM_ARB_RR_EN
    // Remembers the most recent winner so the next tie goes the other way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt0) begin
            r_last_gnt <= 1'b0;
        end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_blram_arbiter.sv
// Testbench for blram_arbiter: directed scenarios followed by randomized traffic,
// each cycle compared with a transaction-level reference model.
module tb_blram_arbiter;

    localparam int SIZE     = 13;
    localparam int LOCK_MAX = 8;
    localparam int DEPTH    = 1 << SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            t_req   [2];
    logic            t_we    [2];
    logic [SIZE-1:0] t_addr  [2];
    logic [15:0]     t_wdata [2];
    logic            t_lock  [2];

    logic            o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_ram_we;
    logic [15:0]     o_rdata0, o_rdata1, o_ram_data_in;
    logic [SIZE-1:0] o_ram_addr;
    logic [15:0]     ram_q;

    blram_arbiter #(.SIZE(SIZE), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req0(t_req[0]), .i_we0(t_we[0]), .i_addr0(t_addr[0]), .i_wdata0(t_wdata[0]),
        .i_lock0(t_lock[0]), .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0), .o_rdata0(o_rdata0),
        .i_req1(t_req[1]), .i_we1(t_we[1]), .i_addr1(t_addr[1]), .i_wdata1(t_wdata[1]),
        .i_lock1(t_lock[1]), .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1), .o_rdata1(o_rdata1),
        .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_data_in(o_ram_data_in),
        .i_ram_data_out(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(int a);
        return 16'(a * 977 + 16'h1234);
    endfunction

    // Block RAM behaviour: synchronous read, contents reloaded during reset.
    logic [15:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
        end else if (o_ram_we) begin
            env_mem[o_ram_addr] <= o_ram_data_in;
        end
        ram_q <= env_mem[o_ram_addr];
    end

    // Reference model: lock owner (-1 = none), cycles the other port has waited,
    // pending read results and a shadow copy of memory.
    int          m_owner;
    int          m_wait;
`ifdef BLRAM_ARB_RR_EN
    int          m_last;
    localparam int FW = 1;
`else
    localparam int FW = 0;
`endif
    bit          m_rv [2];
    logic [15:0] m_rd [2];
    logic [15:0] shadow [DEPTH];

    int n_pass, n_total, n_fail;
    logic        s_g  [2];
    logic        s_rv [2];
    logic [15:0] s_rd [2];
    logic        s_we;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_wait  = 0;
`ifdef BLRAM_ARB_RR_EN
        m_last  = 1;
`endif
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0;
            m_rd[p] = '0;
        end
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    endtask

    function automatic int model_winner();
        int oth;
        if (m_owner < 0) begin
            if (t_req[0] && t_req[1]) begin
`ifdef BLRAM_ARB_RR_EN
                return (m_last == 0) ? 1 : 0;
`else
                return 0;
`endif
            end
            if (t_req[0]) return 0;
            if (t_req[1]) return 1;
            return -1;
        end
        oth = 1 - m_owner;
        if (t_req[oth] && m_wait == LOCK_MAX) return oth;
        if (t_req[m_owner]) return m_owner;
        return -1;
    endfunction

    // One clock cycle: compare outputs against the model, then advance the model.
    task automatic step(bit rst_before_edge);
        int              w;
        int              oth;
        logic            ew;
        logic [SIZE-1:0] ea;
        logic [15:0]     ed;
        logic            erv;
        #3;
        w  = rst ? -1 : model_winner();
        ew = 1'b0;
        ea = '0;
        ed = '0;
        if (w >= 0) begin
            ew = t_we[w];
            ea = t_addr[w];
            ed = t_wdata[w];
        end
        chk("gnt0", o_gnt0, w == 0);
        chk("gnt1", o_gnt1, w == 1);
        chk("ram_we", o_ram_we, ew);
        chk("ram_addr", o_ram_addr, ea);
        chk("ram_data_in", o_ram_data_in, ed);
        erv = rst ? 1'b0 : m_rv[0];
        chk("rvalid0", o_rvalid0, erv);
        chk("rdata0", o_rdata0, erv ? m_rd[0] : 16'h0);
        erv = rst ? 1'b0 : m_rv[1];
        chk("rvalid1", o_rvalid1, erv);
        chk("rdata1", o_rdata1, erv ? m_rd[1] : 16'h0);
        s_g[0] = o_gnt0;     s_g[1] = o_gnt1;
        s_rv[0] = o_rvalid0; s_rv[1] = o_rvalid1;
        s_rd[0] = o_rdata0;  s_rd[1] = o_rdata1;
        s_we = o_ram_we;
        if (rst_before_edge) rst = 1'b1;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_rv[p] = (w == p) && !t_we[p];
                m_rd[p] = shadow[ea];
            end
            if (w >= 0 && ew) shadow[ea] = ed;
`ifdef BLRAM_ARB_RR_EN
            if (w >= 0) m_last = w;
`endif
            if (m_owner < 0) begin
                if (w >= 0 && t_lock[w]) m_owner = w;
                m_wait = 0;
            end else begin
                oth = 1 - m_owner;
                if (!t_req[m_owner] || (w == m_owner && !t_lock[m_owner])) begin
                    m_owner = -1;
                    m_wait  = 0;
                end else if (w == oth || !t_req[oth]) begin
                    m_wait = 0;
                end else begin
                    m_wait++;
                end
            end
        end
        #1;
    endtask

    task automatic hold_step(bit k0, bit k1);
        step(1'b0);
        if (s_g[0] && !k0) t_req[0] = 1'b0;
        if (s_g[1] && !k1) t_req[1] = 1'b0;
    endtask

    task automatic set_port(int p, bit r, bit w, logic [SIZE-1:0] a, logic [15:0] d, bit l);
        t_req[p]   = r;
        t_we[p]    = w;
        t_addr[p]  = a;
        t_wdata[p] = d;
        t_lock[p]  = l;
    endtask

    initial begin
        int          blocked;
        bit          got;
        int          sw;
        int          lock_pct;
        logic [15:0] cval [2];
        n_pass = 0; n_total = 0; n_fail = 0;
        sw = 1 - FW;
        cval[0] = 16'h1111;
        cval[1] = 16'h2222;
        rst = 1'b1;
        model_reset();

        // Reset held with both ports asking for reads.
        set_port(0, 1, 0, 13'h0010, 16'h0, 0);
        set_port(1, 1, 0, 13'h0020, 16'h0, 0);
        repeat (3) step(1'b0);
        rst = 1'b0;
        hold_step(0, 0);
        chk("first_gnt0", s_g[0], 1'b1);
        hold_step(0, 0);
        chk("second_gnt1", s_g[1], 1'b1);

        // Preload, then contention read.
        set_port(0, 1, 1, 13'h0010, 16'h1111, 0); hold_step(0, 0);
        set_port(0, 1, 1, 13'h0020, 16'h2222, 0); hold_step(0, 0);
        set_port(0, 1, 0, 13'h0010, 16'h0, 0);
        set_port(1, 1, 0, 13'h0020, 16'h0, 0);
        hold_step(0, 0);
        chk("cont_first_gnt", s_g[FW], 1'b1);
        hold_step(0, 0);
        chk("cont_first_rvalid", s_rv[FW], 1'b1);
        chk("cont_first_rdata", s_rd[FW], cval[FW]);
        chk("cont_second_gnt", s_g[sw], 1'b1);
        hold_step(0, 0);
        chk("cont_second_rvalid", s_rv[sw], 1'b1);
        chk("cont_second_rdata", s_rd[sw], cval[sw]);

        // Port 1 write then read-back at the top address.
        set_port(1, 1, 1, 13'h1FFF, 16'hBEEF, 0); hold_step(0, 0);
        chk("wr1_ram_we", s_we, 1'b1);
        set_port(1, 1, 0, 13'h1FFF, 16'h0, 0); hold_step(0, 0);
        chk("wr1_no_rvalid", s_rv[1], 1'b0);
        hold_step(0, 0);
        chk("rd1_rvalid", s_rv[1], 1'b1);
        chk("rd1_rdata", s_rd[1], 16'hBEEF);

        // Port 1 holds the lock; port 0 must be let through after LOCK_MAX blocked cycles.
        set_port(1, 1, 0, 13'h0020, 16'h0, 1); hold_step(0, 1);
        chk("lk_acquire_gnt1", s_g[1], 1'b1);
        set_port(0, 1, 0, 13'h0010, 16'h0, 0);
        blocked = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            hold_step(0, 1);
            if (s_g[0]) got = 1'b1;
            else        blocked++;
        end
        chk("lk_p0_served", got, 1'b1);
        chk("lk_blocked_cycles", blocked, LOCK_MAX);
        hold_step(0, 1);
        chk("lk_p1_regains", s_g[1], 1'b1);
        set_port(0, 1, 0, 13'h0010, 16'h0, 0);
        t_lock[1] = 1'b0;
        hold_step(0, 0);
        chk("rel_gnt1", s_g[1], 1'b1);
        hold_step(0, 0);
        chk("rel_p0_next", s_g[0], 1'b1);

        // Reset arrives between a granted read and its data cycle.
        set_port(0, 1, 0, 13'h0010, 16'h0, 0);
        t_req[1] = 1'b0;
        step(1'b1);
        chk("mr_gnt0", s_g[0], 1'b1);
        t_req[0] = 1'b0;
        step(1'b0);
        chk("mr_rvalid_in_rst", s_rv[0], 1'b0);
        rst = 1'b0;
        step(1'b0);
        chk("mr_rvalid_after_rst", s_rv[0], 1'b0);

        // Both ports requesting continuously from reset.
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        set_port(0, 1, 0, 13'h0031, 16'h0, 0);
        set_port(1, 1, 0, 13'h0032, 16'h0, 0);
        for (int i = 0; i < 6; i++) begin
            hold_step(1, 1);
`ifdef BLRAM_ARB_RR_EN
            chk("both_gnt0", s_g[0], (i % 2) == 0);
`else
            chk("both_gnt0", s_g[0], 1'b1);
`endif
        end
        t_req[0] = 1'b0;
        t_req[1] = 1'b0;
        step(1'b0);

        // Randomized traffic; odd segments make locks sticky so starvation relief triggers.
        for (int seg = 0; seg < 12; seg++) begin
            lock_pct = (seg % 2 == 1) ? 95 : 20;
            for (int c = 0; c < 250; c++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!t_req[p] || s_g[p]) begin
                        t_req[p]   = ($urandom_range(99) < 85);
                        t_we[p]    = ($urandom_range(2) == 0);
                        t_addr[p]  = ($urandom_range(3) == 0) ? SIZE'($urandom) : SIZE'($urandom_range(63));
                        t_wdata[p] = 16'($urandom);
                        t_lock[p]  = ($urandom_range(99) < lock_pct);
                    end
                end
                step(1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/blram_arbiter.md
Name: blram_arbiter

Overview:
Two-requester arbiter for the 16-bit single-port block RAM (SIZE-bit address, 1-cycle synchronous read). It shares the RAM between requester 0 (CPU core) and requester 1 (loader/debug DMA). Each cycle it selects at most one requester, drives the RAM port, and routes returned read data one cycle later with a per-port valid. A lock mechanism supports atomic read-modify-write, and a starvation counter bounds how long the lock can block the other port.

Parameters:
SIZE, 13, RAM address width.
LOCK_MAX, 8, maximum consecutive cycles a non-owner may be blocked by a lock before it is granted one access; must be >= 1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
i_req0  input  1  port 0 access request.
i_we0  input  1  port 0 write (1) / read (0).
i_addr0  input  SIZE  port 0 address.
i_wdata0  input  16  port 0 write data.
i_lock0  input  1  port 0 requests/keeps the lock.
o_gnt0  output  1  port 0 granted this cycle (combinational).
o_rvalid0  output  1  port 0 read data valid.
o_rdata0  output  16  port 0 read data.
i_req1, i_we1, i_addr1, i_wdata1, i_lock1, o_gnt1, o_rvalid1, o_rdata1: same as port 0, for port 1.
o_ram_we  output  1  to RAM write enable.
o_ram_addr  output  SIZE  to RAM address.
o_ram_data_in  output  16  to RAM write data.
i_ram_data_out  input  16  from RAM read data (valid one cycle after address).

Behaviour:
- Reset (async, rst=1): state cleared: lock inactive, owner=0, starve_cnt=0, last_gnt=1, rvalid pipeline 0. While rst=1: o_gnt0/1=0, o_ram_we=0, o_rvalid0/1=0, o_rdata0/1=0, o_ram_addr=0, o_ram_data_in=0.
- Request handshake: requester holds req/we/addr/wdata/lock stable until it sees gnt=1 in the same cycle; the access is issued in that cycle. At most one gnt high per cycle. No request means no grant, and o_ram_we=0.
- RAM drive: winner's addr/wdata go to o_ram_addr/o_ram_data_in. o_ram_we = winner's we & gnt. With no grant, addr and data hold 0 and we=0.
- Read latency: a read granted in cycle N produces o_rvalidX=1 in cycle N+1 with o_rdataX=i_ram_data_out; otherwise o_rdataX=0. Writes never assert rvalid. Back-to-back reads give one rvalid per cycle, in order.
- Arbitration, no lock active: fixed priority, port 0 wins when both request (see optional feature).
- Lock acquire: a granted port with its lock=1 becomes owner and the lock goes active at the next edge.
- Lock release: lock is released at the edge after either event:
  - the owner is granted with lock=0;
  - the owner has req=0 in a cycle.
- While the lock is active, only the owner may be granted, except through starvation relief.
- Starvation relief (lock active, non-owner req=1, not granted): starve_cnt increments each such cycle.
  - When starve_cnt==LOCK_MAX, the non-owner is granted that cycle, starve_cnt clears, and the lock remains with the owner.
  - starve_cnt also clears when the lock is released or the non-owner drops req.
  - Net effect: the non-owner is blocked for exactly LOCK_MAX cycles, then served.
- Non-owner's lock input is ignored while the lock is held by the other port.
- Reset mid-operation: pending rvalid is discarded (not asserted after reset releases) and the lock is dropped.
- Read-during-write to the same RAM address in one cycle is impossible (single grant).

Optional Feature:
BLRAM_ARB_RR_EN: when defined, unlocked arbitration is round-robin. When both ports request, the grant goes to the port not equal to last_gnt, and last_gnt updates on every grant. When undefined, fixed priority applies (port 0 wins) and last_gnt is unused. Lock and starvation rules are identical in both builds.

Test Plan:
- Reset: rst=1 with both ports requesting reads -> o_gnt0/1=0, o_ram_we=0, o_rvalid0/1=0. Release rst -> port 0 granted first cycle.
- Contention read: mem[0x0010]=0x1111, mem[0x0020]=0x2222, both request reads from cycle N (fixed priority) -> gnt0 at N, rvalid0/rdata0=0x1111 at N+1; gnt1 at N+1, rvalid1/rdata1=0x2222 at N+2.
- Write then read, port 1: write 0xBEEF to 0x1FFF -> o_ram_we=1, no rvalid1. Read 0x1FFF next -> rvalid1 with 0xBEEF one cycle later.
- Lock starvation: port 1 acquires lock and keeps req=1, lock=1; port 0 requests continuously -> port 0 blocked 8 cycles, gnt0 on 9th cycle, then port 1 regains grants. Port 1 lock=0 grant -> port 0 served next cycle.
- Reset mid-read: read granted at cycle N, rst asserted before edge N+1 -> o_rvalid never asserts for that read.
- BLRAM_ARB_RR_EN defined, both requesting continuously from reset -> grants 0,1,0,1,...; undefined -> grants 0,0,0,...
